// File: rtl/pulse_mask_pkg.sv
// pulse_mask_pkg: FSM state type, DAC level helper and channel field slicing helper
// shared by the pulse_mask_gen block.
package pulse_mask_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned LEVEL_MAX_W = 64;

    // Full-scale level in the low 'width' bits: max positive when the mask is
    // set, most negative otherwise. Callers truncate to their sample width.
    function automatic logic [LEVEL_MAX_W-1:0] mask_level(input int unsigned width,
                                                         input logic        mask_bit);
        logic [LEVEL_MAX_W-1:0] max_pos;
        max_pos = (LEVEL_MAX_W'(1) << (width - 1)) - LEVEL_MAX_W'(1);
        return mask_bit ? max_pos : ~max_pos;
    endfunction

    // LSB of channel 'ch' inside a flattened vector of field_w-wide fields.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned field_w);
        return ch * field_w;
    endfunction

endpackage

// File: rtl/pulse_mask_gen_if.sv
// pulse_mask_gen_if: per-channel configuration, sample inputs and mask outputs.
// master drives duty/delay/din, slave (the generator) drives the gated outputs.
interface pulse_mask_gen_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
);
    logic [N_CH*CNT_W-1:0]  duty;
    logic [N_CH*CNT_W-1:0]  delay;
    logic [N_CH*DATA_W-1:0] din;
    logic [N_CH*DATA_W-1:0] dout;
    logic [N_CH*DATA_W-1:0] mask_dac;
    logic [N_CH-1:0]        mask_dio;

    modport master (
        output duty, delay, din,
        input  dout, mask_dac, mask_dio
    );

    modport slave (
        input  duty, delay, din,
        output dout, mask_dac, mask_dio
    );
endinterface

// File: rtl/pulse_mask_chan.sv
// pulse_mask_chan: one channel's phase compare against the shared counter, sample
// gating and registered dout / DAC level / DIO bit outputs.
module pulse_mask_chan
    import pulse_mask_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [CNT_W-1:0]         count,
    input  logic [CNT_W-1:0]         period,
    input  logic [CNT_W-1:0]         duty,
    input  logic [CNT_W-1:0]         delay,
    input  logic signed [DATA_W-1:0] din,
    output logic [DATA_W-1:0]        dout,
    output logic [DATA_W-1:0]        mask_dac,
    output logic                     mask_dio
);
    logic [CNT_W:0]      ph;
    logic                mask;
    logic [DATA_W-1:0]   dout_d, dout_q;
    logic [DATA_W-1:0]   dac_d, dac_q;
    logic                dio_d, dio_q;

    // Extra bit keeps count+period exact when period is close to 2^CNT_W.
    always_comb begin
        if (count >= delay) begin
            ph = {1'b0, count} - {1'b0, delay};
        end else begin
            ph = {1'b0, count} + {1'b0, period} - {1'b0, delay};
        end
        mask   = run && (ph < {1'b0, duty});
        dout_d = mask ? din : '0;
        dac_d  = DATA_W'(mask_level(DATA_W, mask));
        dio_d  = mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            dac_q  <= DATA_W'(mask_level(DATA_W, 1'b0));
            dio_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            dac_q  <= dac_d;
            dio_q  <= dio_d;
        end
    end

    assign dout     = dout_q;
    assign mask_dac = dac_q;
    assign mask_dio = dio_q;

endmodule

// File: rtl/pulse_mask_gen.sv
// pulse_mask_gen: IDLE/RUN sequencer, shared period counter and burst counter driving
// N_CH pulse_mask_chan instances. Define PULSE_MASK_SHADOW_EN to latch the settings.
module pulse_mask_gen
    import pulse_mask_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 32,
    parameter int N_CH    = 2,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               trigger,
    input  logic [BURST_W-1:0] burst_n,
    input  logic [CNT_W-1:0]   period,
    pulse_mask_gen_if.slave    bus,
    output logic               busy,
    output logic               period_start
);
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BURST_W-1:0]   done_q, done_d;
    logic                 start_q, start_d;
    logic                 busy_q;
    logic                 load;
    logic                 wrap;
    logic                 last;
    logic                 run_eval;

    logic [CNT_W-1:0]       period_a;
    logic [BURST_W-1:0]     burst_a;
    logic [N_CH*CNT_W-1:0]  duty_a;
    logic [N_CH*CNT_W-1:0]  delay_a;
    logic [N_CH*CNT_W-1:0]  delay_red;

    logic [N_CH*DATA_W-1:0] dout_w;
    logic [N_CH*DATA_W-1:0] dac_w;
    logic [N_CH-1:0]        dio_w;

    // Delays at or beyond the period are folded back into 0..P-1.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_red
        assign delay_red[ch_lsb(gi, CNT_W) +: CNT_W] =
            (period == '0) ? '0 : bus.delay[ch_lsb(gi, CNT_W) +: CNT_W] % period;
    end

`ifdef PULSE_MASK_SHADOW_EN
    logic [CNT_W-1:0]      period_sh_q, period_sh_d;
    logic [BURST_W-1:0]    burst_sh_q, burst_sh_d;
    logic [N_CH*CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [N_CH*CNT_W-1:0] delay_sh_q, delay_sh_d;

    always_comb begin
        period_sh_d = period_sh_q;
        burst_sh_d  = burst_sh_q;
        duty_sh_d   = duty_sh_q;
        delay_sh_d  = delay_sh_q;
        if (load) begin
            period_sh_d = period;
            burst_sh_d  = burst_n;
            duty_sh_d   = bus.duty;
            delay_sh_d  = delay_red;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_sh_q <= '0;
            burst_sh_q  <= '0;
            duty_sh_q   <= '0;
            delay_sh_q  <= '0;
        end else begin
            period_sh_q <= period_sh_d;
            burst_sh_q  <= burst_sh_d;
            duty_sh_q   <= duty_sh_d;
            delay_sh_q  <= delay_sh_d;
        end
    end

    assign period_a = period_sh_q;
    assign burst_a  = burst_sh_q;
    assign duty_a   = duty_sh_q;
    assign delay_a  = delay_sh_q;
`else
    assign period_a = period;
    assign burst_a  = burst_n;
    assign duty_a   = bus.duty;
    assign delay_a  = delay_red;
`endif

    // >= rather than == so a live period shrink below the count still wraps.
    assign wrap     = ({1'b0, count_q} + (CNT_W+1)'(1)) >= {1'b0, period_a};
    assign last     = (burst_a != '0) &&
                      (({1'b0, done_q} + (BURST_W+1)'(1)) >= {1'b0, burst_a});
    assign run_eval = (state_q == RUN) && (period_a != '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        start_d = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (period != '0) && ((burst_n == '0) || trigger)) begin
                    state_d = RUN;
                    count_d = '0;
                    done_d  = '0;
                    start_d = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!enable || (period_a == '0)) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (wrap) begin
                    count_d = '0;
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        done_d  = done_q + BURST_W'(1);
                        start_d = 1'b1;
                        load    = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            start_q <= start_d;
            busy_q  <= (state_d == RUN);
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pulse_mask_chan #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .run      (run_eval),
            .count    (count_q),
            .period   (period_a),
            .duty     (duty_a[ch_lsb(gi, CNT_W) +: CNT_W]),
            .delay    (delay_a[ch_lsb(gi, CNT_W) +: CNT_W]),
            .din      (bus.din[ch_lsb(gi, DATA_W) +: DATA_W]),
            .dout     (dout_w[ch_lsb(gi, DATA_W) +: DATA_W]),
            .mask_dac (dac_w[ch_lsb(gi, DATA_W) +: DATA_W]),
            .mask_dio (dio_w[gi])
        );
    end

    assign bus.dout     = dout_w;
    assign bus.mask_dac = dac_w;
    assign bus.mask_dio = dio_w;
    assign busy         = busy_q;
    assign period_start = start_q;

endmodule

// File: doc/pulse_mask_gen.md
# pulse_mask_gen

Multi-channel, parametrised pulse-mask generator for the swept-pulse instrument path. A shared period counter drives N_CH independent channels, each with its own duty and phase delay, and each gates its own signed input sample onto its output. Masks also appear as full-scale DAC levels and DIO bits. Supports continuous and triggered-burst operation and sits between the input ADC samples and the output DAC/DIO mux.

## Interface
- DATA_W, 16: sample width, signed
- CNT_W, 32: period/duty/delay counter width
- N_CH, 2: channel count, 1..8
- BURST_W, 16: burst-count width
- clk  in  1  sample clock
- reset  in  1  synchronous, active-high
- enable  in  1  global run enable
- trigger  in  1  burst start (level sampled each cycle)
- burst_n  in  BURST_W  periods per burst; 0 = continuous
- period  in  CNT_W  period in clocks, unsigned; 0 = disabled
- duty  in  N_CH*CNT_W  per-channel high time in clocks; ch c at [c*CNT_W +: CNT_W]
- delay  in  N_CH*CNT_W  per-channel phase offset in clocks
- din  in  N_CH*DATA_W  per-channel signed passthrough samples
- dout  out  N_CH*DATA_W  gated samples
- mask_dac  out  N_CH*DATA_W  mask as max positive / max negative
- mask_dio  out  N_CH  mask bits
- busy  out  1  high in RUN
- period_start  out  1  one-cycle strobe at count==0 in RUN

## Operation
- FSM states: IDLE, RUN.
- IDLE -> RUN:
  - continuous: when enable=1, burst_n=0 and period!=0.
  - burst: when enable=1, burst_n!=0, period!=0 and trigger=1.
- RUN -> IDLE:
  - immediately when enable=0 or active period==0.
  - in burst mode, at the wrap that ends period number burst_n.
- trigger is ignored in RUN; no retrigger or queueing.
- Counter runs 0..P-1 and wraps to 0. A period counter counts completed periods in burst mode.
- Per-channel phase: ph = count-delay_c if count>=delay_c, else count+P-delay_c. If delay_c>=P, use delay_c mod P, computed once at latch time.
- Mask: mask_c = RUN && (ph < duty_c).
  - duty_c=0: always low.
  - duty_c>=P: always high.
- Outputs per channel:
  - dout = mask ? din : 0.
  - mask_dac = mask ? 2^(DATA_W-1)-1 : -2^(DATA_W-1).
  - mask_dio = mask.
- Arithmetic: unsigned, CNT_W+1 bits internally for count+P, so no overflow at P near 2^CNT_W.
- Reset values: dout 0, mask_dac most negative, mask_dio 0, busy 0, period_start 0, count 0, FSM IDLE.

## Timing
- All outputs are registered. mask/dout/dac/dio reflect the count value from the previous cycle (1-cycle latency).
- din is sampled in the same cycle the count is evaluated.
- First RUN cycle: count=0 and period_start=1. The channel with delay=0 and duty>0 shows its mask high one cycle later.
- enable falling: the FSM is IDLE on the next cycle and the masks are low the cycle after that.
- Burst end: the last period completes fully (count reaches P-1). The masks are low from the following cycle's output.
- reset mid-run: all state returns to reset values on the next edge, regardless of other inputs.
- trigger and enable deassertion in the same cycle: the deassertion wins and the FSM stays IDLE.

## Configuration
- PULSE_MASK_SHADOW_EN defined:
  - period, duty, delay and burst_n are latched into shadow registers on IDLE->RUN and at every wrap (count==P-1 -> 0).
  - Mid-period changes take effect at the next period boundary.
- PULSE_MASK_SHADOW_EN undefined:
  - inputs are used live every cycle.
  - If count>=new period, the counter wraps on the next cycle.

## Structure
- Package pulse_mask_pkg holds:
  - state enum (IDLE, RUN)
  - function mask_level(width, bit) returning max positive / max negative
  - channel field slice helpers
- Sub-module pulse_mask_chan holds the per-channel phase compare, gating and output registers, generated N_CH times.
- The top level holds the FSM, counters and shadow registers.

## Test plan
- Continuous, P=4, ch0 duty=2 delay=0: mask_dio0 pattern 1100 repeating from cycle 2 after enable; dout0=din0 when high, 0 otherwise; mask_dac0=0x7FFF/0x8000.
- Phase delay, P=8, ch1 duty=3 delay=6: ch1 high at counts 6,7,0; wrap-spanning pulse is contiguous.
- Burst, burst_n=3, P=5, duty=2: one trigger gives exactly 3 period_start strobes and 6 high cycles, then busy=0; a second trigger during RUN has no effect.
- Boundaries:
  - duty=0: always low.
  - duty=P: always high.
  - period=0: stays IDLE, outputs at reset values.
- Shadow (macro on): change duty 2->3 at count=1 of P=6; the current period keeps duty 2 and the next period shows 3. Macro off: the change applies immediately.
- reset asserted mid-burst at count=2: next cycle all outputs at reset values and busy=0.
